mmio_dbg_bridge: RTL and testbench
==================================

// Module: mmio_dbg_bridge
// PURPOSE
//  Byte-stream-to-FPro-bus initiator: parses read/write command frames from a byte source (UART RX
//  FIFO side) and issues single mmio transactions to the mmio subsystem (mmio_controller + slots).
//  Returns write acks / read data as bytes to a byte sink (UART TX side). Gives host debug access to
//  all I/O slots without the CPU.
// PARAMETERS
//  ADDR_W          21         mmio address width (matches mmio_addr)
//  DATA_W          32         mmio data width
//  TIMEOUT_CYCLES  1_000_000  inter-byte timeout in clk cycles; used only with DBG_BRIDGE_TIMEOUT_EN
// PORTS
//  clk           in   1   system clock
//  reset         in   1   synchronous, active-high reset
//  rx_data       in   8   command byte
//  rx_valid      in   1   rx_data valid
//  rx_ready      out  1   byte consumed on rx_valid & rx_ready
//  tx_data       out  8   response byte
//  tx_valid      out  1   tx_data valid; held until tx_ready
//  tx_ready      in   1   sink accepts tx_data
//  mmio_cs       out  1   bus chip select
//  mmio_wr       out  1   write strobe
//  mmio_rd       out  1   read strobe
//  mmio_addr     out  21  bus address
//  mmio_wr_data  out  32  write data
//  mmio_rd_data  in   32  read data (combinational from slot, valid in strobe cycle)
// BEHAVIOUR
//  - Frames (multi-byte fields MSB first): WR = 0x57,A2,A1,A0,D3,D2,D1,D0 -> reply 0x4B.
//    RD = 0x52,A2,A1,A0 -> reply D3,D2,D1,D0. Other cmd byte -> reply 0x3F, back to IDLE.
//  - A2[7:5] discarded; mmio_addr = {A2[4:0],A1,A0}.
//  - FSM: IDLE -> ADDR(3 bytes) -> WDATA(4 bytes, WR only) -> BUS -> RESP(1 or 4 bytes) -> IDLE.
//    Unknown cmd: IDLE -> RESP(0x3F, 1 byte) -> IDLE.
//  - rx_ready = 1 only in IDLE/ADDR/WDATA and reset low; rx_valid elsewhere ignored, not consumed.
//  - Bus cycle: cs and wr|rd registered, high for exactly 1 cycle, in the cycle after the last frame
//    byte is accepted (cycle N+1). Never cs without wr or rd; wr and rd never together.
//  - mmio_addr/mmio_wr_data registered, stable from strobe cycle until next frame loads them.
//  - Read: mmio_rd_data captured at the end of the strobe cycle.
//  - Response: tx_valid rises at N+2. Next byte is presented the cycle after each tx handshake;
//    tx_data stable while tx_valid & !tx_ready. IDLE re-entered the cycle after the last handshake.
//  - Reset values: rx_ready 0 during reset, 1 after (IDLE); tx_valid 0, tx_data 0, cs/wr/rd 0,
//    addr 0, wr_data 0; state IDLE.
//  - Reset mid-frame or mid-response: partial frame dropped, pending response discarded, no strobe.
//  - Back-to-back frames: a cmd byte offered in the same cycle IDLE is re-entered is accepted.
// CONFIGURATION
//  DBG_BRIDGE_TIMEOUT_EN defined: counter cleared on every accepted byte and on IDLE entry, counts
//   in ADDR/WDATA; when it reaches TIMEOUT_CYCLES-1 without a byte -> IDLE next cycle, no bus
//   cycle, no response. Undefined: no counter; ADDR/WDATA wait indefinitely; TIMEOUT_CYCLES unused.
// STRUCTURE
//  - Package dbg_bridge_pkg: state enum (IDLE, ADDR, WDATA, BUS, RESP), CMD_WR=8'h57,
//    CMD_RD=8'h52, RSP_ACK=8'h4B, RSP_ERR=8'h3F, byte-count widths.
//  - One sub-module: dbg_rsp_shifter (loads 1 or 4 bytes, valid/ready shift-out); the
//    parser FSM, byte counter, and timeout counter stay in the top.
// TESTING
//  1 WR 57 00 00 40 DE AD BE EF -> one cycle cs=wr=1, addr=0x000040, wr_data=0xDEADBEEF; tx 4B.
//  2 RD 52 1F FF FF, slot drives 0x12345678 -> one cycle cs=rd=1, addr=0x1FFFFF; tx 12 34 56 78.
//    RD 52 E0 00 08 -> addr=0x000008.
//  3 Byte 41 -> tx 3F, no cs; next RD 52 00 00 04 is executed normally.
//  4 RD with tx_ready low 10 cycles per byte -> tx_data stable, rx_ready=0, exactly 4 bytes out.
//  5 reset pulse after 57 00 -> no strobe, tx_valid=0; then RD 52 00 00 10 works.
//  6 [DBG_BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=16] 52 00 then 16 idle cycles -> IDLE, no response;
//    RD 52 00 00 04 then reads addr 0x000004.

Source files
------------

// File: rtl/dbg_bridge_pkg.sv
// Shared types and constants for the byte-stream debug bridge: parser states,
// command/response codes and counter widths.
package dbg_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    BUS,
    RESP
  } state_t;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h3F;

  localparam int ADDR_BYTES = 3;
  localparam int DATA_BYTES = 4;
  localparam int BYTE_CNT_W = 2;
  localparam int RSP_CNT_W  = 3;

  function automatic logic is_known_cmd(input logic [7:0] b);
    return (b == CMD_WR) || (b == CMD_RD);
  endfunction

endpackage

// File: rtl/dbg_rsp_shifter.sv
// Response byte shifter: loads a 1-byte code or a full data word and shifts it
// out MSB first over a valid/ready byte interface.
module dbg_rsp_shifter
  import dbg_bridge_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              load_wide,
  input  logic [DATA_W-1:0] load_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              done
);

  logic [DATA_W-1:0]    sh;
  logic [RSP_CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sh  <= '0;
      cnt <= '0;
    end else if (load) begin
      // narrow loads take only the top byte, so a code occupies bits [DATA_W-1 -: 8]
      sh  <= load_wide ? load_data : {load_data[DATA_W-1 -: 8], {(DATA_W-8){1'b0}}};
      cnt <= load_wide ? RSP_CNT_W'(DATA_W / 8) : RSP_CNT_W'(1);
    end else if (tx_valid && tx_ready) begin
      sh  <= sh << 8;
      cnt <= cnt - 1'b1;
    end
  end

  assign tx_valid = (cnt != '0);
  assign tx_data  = sh[DATA_W-1 -: 8];
  assign done     = tx_valid && tx_ready && (cnt == RSP_CNT_W'(1));

endmodule

// File: rtl/mmio_dbg_bridge.sv
// Host debug bridge: parses WR/RD command frames from a byte stream, issues one
// mmio transaction per frame and streams the ack/read data back.
// Optional inter-byte timeout is enabled with `define DBG_BRIDGE_TIMEOUT_EN.
module mmio_dbg_bridge
  import dbg_bridge_pkg::*;
#(
  parameter int ADDR_W         = 21,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              mmio_cs,
  output logic              mmio_wr,
  output logic              mmio_rd,
  output logic [ADDR_W-1:0] mmio_addr,
  output logic [DATA_W-1:0] mmio_wr_data,
  input  logic [DATA_W-1:0] mmio_rd_data
);

  // Handshakes: a byte moves on rx_valid & rx_ready (resp. tx_valid & tx_ready)
  // at a rising edge; a source holds valid and data stable until that edge.

  state_t                state, state_next;
  logic [BYTE_CNT_W-1:0] byte_cnt;
  logic                  cmd_wr;
  logic [ADDR_W-1:0]     addr_sh;
  logic [DATA_W-1:0]     data_sh;
  logic                  rx_acc;
  logic                  frame_done;
  logic                  rsp_load;
  logic                  rsp_wide;
  logic [DATA_W-1:0]     rsp_data;
  logic                  rsp_done;
  logic                  timeout_hit;

  assign rx_ready = !reset && ((state == IDLE) || (state == ADDR) || (state == WDATA));
  assign rx_acc   = rx_valid && rx_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    frame_done = 1'b0;
    rsp_load   = 1'b0;
    rsp_wide   = 1'b0;
    rsp_data   = '0;
    case (state)
      IDLE: begin
        if (rx_acc) begin
          if (is_known_cmd(rx_data)) begin
            state_next = ADDR;
          end else begin
            state_next = RESP;
            rsp_load   = 1'b1;
            rsp_data   = {RSP_ERR, {(DATA_W-8){1'b0}}};
          end
        end
      end
      ADDR: begin
        if (rx_acc && (byte_cnt == BYTE_CNT_W'(ADDR_BYTES - 1))) begin
          state_next = cmd_wr ? WDATA : BUS;
          frame_done = !cmd_wr;
        end else if (timeout_hit) begin
          state_next = IDLE;
        end
      end
      WDATA: begin
        if (rx_acc && (byte_cnt == BYTE_CNT_W'(DATA_BYTES - 1))) begin
          state_next = BUS;
          frame_done = 1'b1;
        end else if (timeout_hit) begin
          state_next = IDLE;
        end
      end
      BUS: begin
        // strobe cycle: read data is valid now and is captured by the shifter load
        state_next = RESP;
        rsp_load   = 1'b1;
        rsp_wide   = !cmd_wr;
        rsp_data   = cmd_wr ? {RSP_ACK, {(DATA_W-8){1'b0}}} : mmio_rd_data;
      end
      RESP: begin
        if (rsp_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt     <= '0;
      cmd_wr       <= 1'b0;
      addr_sh      <= '0;
      data_sh      <= '0;
      mmio_cs      <= 1'b0;
      mmio_wr      <= 1'b0;
      mmio_rd      <= 1'b0;
      mmio_addr    <= '0;
      mmio_wr_data <= '0;
    end else begin
      mmio_cs <= frame_done;
      mmio_wr <= frame_done && cmd_wr;
      mmio_rd <= frame_done && !cmd_wr;
      if (state == IDLE) begin
        byte_cnt <= '0;
        if (rx_acc) cmd_wr <= (rx_data == CMD_WR);
      end
      if (rx_acc && (state == ADDR)) begin
        // A2[7:5] fall off the top after three shifts
        addr_sh  <= {addr_sh[ADDR_W-9:0], rx_data};
        byte_cnt <= (byte_cnt == BYTE_CNT_W'(ADDR_BYTES - 1)) ? '0 : byte_cnt + 1'b1;
      end
      if (rx_acc && (state == WDATA)) begin
        data_sh  <= {data_sh[DATA_W-9:0], rx_data};
        byte_cnt <= byte_cnt + 1'b1;
      end
      if (frame_done) begin
        if (cmd_wr) begin
          mmio_addr    <= addr_sh;
          mmio_wr_data <= {data_sh[DATA_W-9:0], rx_data};
        end else begin
          mmio_addr    <= {addr_sh[ADDR_W-9:0], rx_data};
        end
      end
    end
  end

`ifdef DBG_BRIDGE_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] to_cnt;
  logic            in_frame;

  assign in_frame = (state == ADDR) || (state == WDATA);

  always_ff @(posedge clk) begin
    if (reset || rx_acc || !in_frame) to_cnt <= '0;
    else                              to_cnt <= to_cnt + 1'b1;
  end

  assign timeout_hit = in_frame && !rx_acc && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  // never true; frames wait indefinitely for their next byte
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  dbg_rsp_shifter #(
    .DATA_W (DATA_W)
  ) u_rsp (
    .clk       (clk),
    .reset     (reset),
    .load      (rsp_load),
    .load_wide (rsp_wide),
    .load_data (rsp_data),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .done      (rsp_done)
  );

endmodule

// File: tb/tb_mmio_dbg_bridge.sv
// Directed bench for mmio_dbg_bridge: frame parsing, bus strobe timing,
// response streaming, backpressure, reset abort and back-to-back frames.
module tb_mmio_dbg_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        mmio_cs, mmio_wr, mmio_rd;
  logic [20:0] mmio_addr;
  logic [31:0] mmio_wr_data;
  logic [31:0] mmio_rd_data;
  logic [31:0] slot_data = 32'h0;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  logic [7:0] exp_q[$];
  logic       hold_prev = 1'b0;
  logic [7:0] hold_data = 8'h00;

  assign mmio_rd_data = slot_data;

  mmio_dbg_bridge #(
    .ADDR_W         (21),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .mmio_cs      (mmio_cs),
    .mmio_wr      (mmio_wr),
    .mmio_rd      (mmio_rd),
    .mmio_addr    (mmio_addr),
    .mmio_wr_data (mmio_wr_data),
    .mmio_rd_data (mmio_rd_data)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // monitor + scoreboard: samples after inputs settle on the falling edge
  always @(negedge clk) begin
    #2;
    if (reset) begin
      hold_prev = 1'b0;
    end else begin
      if (mmio_cs || mmio_wr || mmio_rd) begin
        checks++;
        if (!(mmio_cs && (mmio_wr ^ mmio_rd))) begin
          errors++;
          $display("FAIL strobe_protocol: cs/wr/rd got %b%b%b required 110 or 101", mmio_cs, mmio_wr, mmio_rd);
        end
        if (mmio_cs) strobe_cnt++;
      end
      if (hold_prev) begin
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== hold_data) begin
          errors++;
          $display("FAIL tx_hold: got valid=%b data=%h required valid=1 data=%h", tx_valid, tx_data, hold_data);
        end
      end
      if (tx_valid && tx_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tx_extra: got byte %h required none", tx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            errors++;
            $display("FAIL tx_byte: got %h required %h", tx_data, e);
          end
        end
      end
      hold_prev = tx_valid && !tx_ready;
      hold_data = tx_data;
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b, output int waited);
    rx_data  = b;
    rx_valid = 1'b1;
    waited   = 0;
    while (!rx_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!rx_ready) begin
      checks++;
      errors++;
      $display("FAIL rx_accept: byte %h not accepted within %0d cycles", b, waited);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_bytes(input logic [63:0] v, input int n);
    int w;
    for (int i = 0; i < n; i++) send_byte(v[8*(n-1-i) +: 8], w);
  endtask

  task automatic wait_rsp(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_rsp: got %0d bytes missing required 0", name, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_tx_idle: got tx_valid=%b required 0", name, tx_valid);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (rx_ready !== 1'b0 || tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_io: got rx_ready=%b tx_valid=%b tx_data=%h required 0 0 00", rx_ready, tx_valid, tx_data);
    end
    checks++;
    if ({mmio_cs, mmio_wr, mmio_rd} !== 3'b000 || mmio_addr !== 21'h0 || mmio_wr_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: got cs/wr/rd=%b addr=%h wdata=%h required 000 0 0",
               {mmio_cs, mmio_wr, mmio_rd}, mmio_addr, mmio_wr_data);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got rx_ready=%b required 1", rx_ready);
    end
  endtask

  task automatic test_write();
    int s0 = strobe_cnt;
    exp_q.push_back(8'h4B);
    send_bytes(64'h57000040DEADBEEF, 8);
    checks++;
    if ({mmio_cs, mmio_wr, mmio_rd} !== 3'b110 || mmio_addr !== 21'h000040 || mmio_wr_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_strobe: got cs/wr/rd=%b addr=%h wdata=%h required 110 000040 deadbeef",
               {mmio_cs, mmio_wr, mmio_rd}, mmio_addr, mmio_wr_data);
    end
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL write_tx_early: got tx_valid=%b required 0", tx_valid);
    end
    @(negedge clk);
    checks++;
    if (mmio_cs !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'h4B) begin
      errors++;
      $display("FAIL write_ack_timing: got cs=%b tx_valid=%b tx_data=%h required 0 1 4b", mmio_cs, tx_valid, tx_data);
    end
    wait_rsp("write");
    checks++;
    if (strobe_cnt - s0 != 1) begin
      errors++;
      $display("FAIL write_strobe_count: got %0d required 1", strobe_cnt - s0);
    end
  endtask

  task automatic test_read();
    int s0 = strobe_cnt;
    slot_data = 32'h12345678;
    push_word(32'h12345678);
    send_bytes(64'h521FFFFF, 4);
    checks++;
    if ({mmio_cs, mmio_wr, mmio_rd} !== 3'b101 || mmio_addr !== 21'h1FFFFF || mmio_wr_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_strobe: got cs/wr/rd=%b addr=%h wdata=%h required 101 1fffff deadbeef",
               {mmio_cs, mmio_wr, mmio_rd}, mmio_addr, mmio_wr_data);
    end
    @(negedge clk);
    slot_data = 32'h0;
    wait_rsp("read");
    checks++;
    if (strobe_cnt - s0 != 1) begin
      errors++;
      $display("FAIL read_strobe_count: got %0d required 1", strobe_cnt - s0);
    end
    slot_data = 32'h0BADF00D;
    push_word(32'h0BADF00D);
    send_bytes(64'h52E00008, 4);
    checks++;
    if ({mmio_cs, mmio_rd} !== 2'b11 || mmio_addr !== 21'h000008) begin
      errors++;
      $display("FAIL read_addr_mask: got cs/rd=%b addr=%h required 11 000008", {mmio_cs, mmio_rd}, mmio_addr);
    end
    wait_rsp("read_mask");
  endtask

  task automatic test_bad_cmd();
    int s0 = strobe_cnt;
    exp_q.push_back(8'h3F);
    send_bytes(64'h41, 1);
    checks++;
    if (mmio_cs !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'h3F) begin
      errors++;
      $display("FAIL bad_cmd_reply: got cs=%b tx_valid=%b tx_data=%h required 0 1 3f", mmio_cs, tx_valid, tx_data);
    end
    wait_rsp("bad_cmd");
    checks++;
    if (strobe_cnt != s0) begin
      errors++;
      $display("FAIL bad_cmd_strobe: got %0d strobes required 0", strobe_cnt - s0);
    end
    slot_data = 32'hA5A50001;
    push_word(32'hA5A50001);
    send_bytes(64'h52000004, 4);
    checks++;
    if ({mmio_cs, mmio_rd} !== 2'b11 || mmio_addr !== 21'h000004) begin
      errors++;
      $display("FAIL bad_cmd_next_read: got cs/rd=%b addr=%h required 11 000004", {mmio_cs, mmio_rd}, mmio_addr);
    end
    wait_rsp("bad_cmd_next");
  endtask

  task automatic test_backpressure();
    int bad_ready = 0;
    int n;
    tx_ready  = 1'b0;
    slot_data = 32'hCAFEF00D;
    push_word(32'hCAFEF00D);
    send_bytes(64'h52000020, 4);
    checks++;
    if (mmio_rd !== 1'b1 || mmio_addr !== 21'h000020) begin
      errors++;
      $display("FAIL bp_strobe: got rd=%b addr=%h required 1 000020", mmio_rd, mmio_addr);
    end
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!tx_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      repeat (10) begin
        @(negedge clk);
        if (rx_ready !== 1'b0) bad_ready++;
      end
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
    end
    checks++;
    if (bad_ready != 0) begin
      errors++;
      $display("FAIL bp_rx_ready: got %0d cycles with rx_ready high required 0", bad_ready);
    end
    checks++;
    if (exp_q.size() != 0 || tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_end: got left=%0d tx_valid=%b rx_ready=%b required 0 0 1", exp_q.size(), tx_valid, rx_ready);
    end
    tx_ready = 1'b1;
    wait_rsp("bp");
  endtask

  task automatic test_back_to_back();
    int w;
    exp_q.push_back(8'h4B);
    send_bytes(64'h5700010011223344, 8);
    send_byte(8'h52, w);
    checks++;
    if (w != 2) begin
      errors++;
      $display("FAIL b2b_accept_cycle: got wait %0d required 2", w);
    end
    slot_data = 32'h55667788;
    push_word(32'h55667788);
    send_bytes(64'h00000C, 3);
    checks++;
    if (mmio_rd !== 1'b1 || mmio_addr !== 21'h00000C || mmio_wr_data !== 32'h11223344) begin
      errors++;
      $display("FAIL b2b_read: got rd=%b addr=%h wdata=%h required 1 00000c 11223344", mmio_rd, mmio_addr, mmio_wr_data);
    end
    wait_rsp("b2b");
  endtask

  task automatic test_reset_mid();
    int s0 = strobe_cnt;
    send_bytes(64'h5700, 2);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_rx_ready: got %b required 0", rx_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (strobe_cnt != s0 || tx_valid !== 1'b0 || mmio_wr_data !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_frame: got strobes=%0d tx_valid=%b wdata=%h required 0 0 0", strobe_cnt - s0, tx_valid, mmio_wr_data);
    end
    tx_ready  = 1'b0;
    slot_data = 32'h99887766;
    send_bytes(64'h52000030, 4);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tx_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_resp: got tx_valid=%b tx_data=%h required 0 00", tx_valid, tx_data);
    end
    repeat (6) @(negedge clk);
    slot_data = 32'h13572468;
    push_word(32'h13572468);
    send_bytes(64'h52000010, 4);
    checks++;
    if (mmio_rd !== 1'b1 || mmio_addr !== 21'h000010) begin
      errors++;
      $display("FAIL rst_recover_read: got rd=%b addr=%h required 1 000010", mmio_rd, mmio_addr);
    end
    wait_rsp("rst_recover");
  endtask

  task automatic test_timeout();
    int s0 = strobe_cnt;
    send_bytes(64'h5200, 2);
`ifdef DBG_BRIDGE_TIMEOUT_EN
    repeat (16) @(negedge clk);
    checks++;
    if (strobe_cnt != s0 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_drop: got strobes=%0d tx_valid=%b required 0 0", strobe_cnt - s0, tx_valid);
    end
    slot_data = 32'h2468ACE0;
    push_word(32'h2468ACE0);
    send_bytes(64'h52000004, 4);
`else
    repeat (20) @(negedge clk);
    checks++;
    if (strobe_cnt != s0 || tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_frame: got strobes=%0d tx_valid=%b rx_ready=%b required 0 0 1", strobe_cnt - s0, tx_valid, rx_ready);
    end
    slot_data = 32'h2468ACE0;
    push_word(32'h2468ACE0);
    send_bytes(64'h0004, 2);
`endif
    checks++;
    if ({mmio_cs, mmio_rd} !== 2'b11 || mmio_addr !== 21'h000004) begin
      errors++;
      $display("FAIL timeout_read: got cs/rd=%b addr=%h required 11 000004", {mmio_cs, mmio_rd}, mmio_addr);
    end
    wait_rsp("timeout");
  endtask

  // sequence + report
  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_cmd();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
